// File: rtl/imem_if.sv
// Instruction-memory read bus: registered req/addr from the fetch unit,
// gnt/rvalid/rdata from memory. One rvalid is returned per granted request.
interface imem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: one outstanding imem read, {pc,instr} prefetch FIFO to decode.
// States: S_IDLE ready to issue | S_REQ req out | S_WAIT await rvalid | S_DROP discard rvalid. Option: FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  output logic          pc_advance,
  input  logic          flush,
  imem_if.master        imem,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          dec_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic          fetch_fault
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fifo_pc_q    [DEPTH];
  logic [DW-1:0] fifo_instr_q [DEPTH];
  logic          push, pop;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          fault_q, fault_d;
  assign fetch_fault = fault_q;
`endif

  assign instr_valid = (count_q != '0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign pc_advance  = req_q & imem.gnt;
  assign imem.req    = req_q;
  assign imem.addr   = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = flush ? 1'b0 : fault_q;
`endif
    // addr_q doubles as the tag of the outstanding request
    push     = (state_q == S_WAIT) & imem.rvalid & ~flush;
    pop      = instr_valid & dec_ready & ~flush;
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (fault_q || pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
          end else if (count_q < DEPTH_C) begin
            state_d = S_REQ;
            addr_d  = pc;
          end
`else
          if (count_q < DEPTH_C) begin
            state_d = S_REQ;
            addr_d  = pc;
          end
`endif
        end
      end
      S_REQ: begin
        if (imem.gnt)  state_d = flush ? S_DROP : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (count_d < DEPTH_C) begin
            state_d = S_REQ;
            addr_d  = pc;
          end else begin
            state_d = S_IDLE;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem.rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= addr_q;
        fifo_instr_q[wr_ptr_q] <= imem.rdata;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus randomized traffic against
// a queue-based model of the prefetch buffer and a latency-driven memory.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc;
  logic          flush;
  logic          dec_ready;
  logic          pc_advance;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          fetch_fault;
`endif

  imem_if #(.AW(AW), .DW(DW)) imem_bus ();

  instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem        (imem_bus),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .dec_ready   (dec_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: decode-visible buffer and the single memory transaction.
  logic [63:0] fq[$];
  bit          outst;
  bit          drop;
  int          mem_wait;
  logic [31:0] pend_data;
  logic [31:0] tag;
  int          gnt_sel;
  int          lat_min, lat_max;

  logic        s_req, s_adv, s_rvalid;
  logic [31:0] s_addr;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, sample pre-edge, update model, check post-edge.
  task automatic tick();
    bit gnt_b;
    bit grant;
    imem_bus.rvalid = outst && (mem_wait == 0);
    imem_bus.rdata  = imem_bus.rvalid ? pend_data : $urandom;
    gnt_b = (gnt_sel == 2) ? ($urandom_range(1, 0) == 1) : (gnt_sel == 1);
    imem_bus.gnt = gnt_b;
    #2;
    s_req    = imem_bus.req;
    s_adv    = pc_advance;
    s_addr   = imem_bus.addr;
    s_rvalid = imem_bus.rvalid;
    chk("pc_advance", 64'(s_adv), 64'(s_req & gnt_b));
    if (s_req) begin
      chk("one_outstanding", 64'(outst), 64'(0));
      chk("req_room", 64'(fq.size()), 64'(fq.size() < DEPTH ? fq.size() : -1));
      if (!flush) chk("req_addr", 64'(s_addr), 64'(pc));
    end
    grant = s_req && gnt_b;

    if (flush) begin
      fq.delete();
    end else begin
      if (fq.size() != 0 && dec_ready) void'(fq.pop_front());
      if (s_rvalid && !drop) fq.push_back({tag, pend_data});
    end
    if (s_rvalid) begin
      outst = 1'b0;
      drop  = 1'b0;
    end else if (outst) begin
      if (flush) drop = 1'b1;
      mem_wait--;
    end
    if (grant) begin
      outst     = 1'b1;
      drop      = flush;
      tag       = s_addr;
      pend_data = $urandom;
      mem_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
    end

    @(posedge clk);
    #1;
    if (grant && !flush) pc = pc + 32'd4;
    imem_bus.rvalid = 1'b0;
    chk("instr_valid", 64'(instr_valid), 64'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("instr_pc", 64'(instr_pc), 64'(fq[0][63:32]));
      chk("instr", 64'(instr), 64'(fq[0][31:0]));
    end
  endtask

  task automatic wait_req(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      seen = s_req;
    end
    chk({name, "_timeout"}, 64'(seen), 64'(1));
  endtask

  initial begin
    logic [31:0] held_addr;
    rst_n = 1'b1; pc = '0; flush = 1'b0; dec_ready = 1'b0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
    outst = 1'b0; drop = 1'b0; mem_wait = 0; pend_data = '0; tag = '0;
    gnt_sel = 1; lat_min = 1; lat_max = 1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", 64'(imem_bus.req), 64'(0));
    chk("rst_addr", 64'(imem_bus.addr), 64'(0));
    chk("rst_adv", 64'(pc_advance), 64'(0));
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(0));
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", 64'(fetch_fault), 64'(0));
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch latency from reset: req/advance in cycle 1, instr_valid in cycle 3.
    tick();
    chk("t1_c0_req", 64'(s_req), 64'(0));
    tick();
    chk("t1_c1_req", 64'(s_req), 64'(1));
    chk("t1_c1_adv", 64'(s_adv), 64'(1));
    chk("t1_c1_addr", 64'(s_addr), 64'(0));
    tick();
    chk("t1_c2_adv", 64'(s_adv), 64'(0));
    chk("t1_c3_valid", 64'(instr_valid), 64'(1));
    chk("t1_c3_pc", 64'(instr_pc), 64'(0));

    // Fill to DEPTH with decode stalled, then drain in order.
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_full_no_req", 64'(s_req), 64'(0));
    end
    chk("t2_head0", 64'(instr_pc), 64'(0));
    dec_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t2_pop_order", 64'(instr_pc), 64'(k * 4));
    end

    // Grant withheld: request and address held, no advance.
    gnt_sel = 0;
    wait_req("t3_req", 12);
    held_addr = s_addr;
    chk("t3_adv0", 64'(s_adv), 64'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_req_held", 64'(s_req), 64'(1));
      chk("t3_addr_held", 64'(s_addr), 64'(held_addr));
      chk("t3_adv_held", 64'(s_adv), 64'(0));
    end
    gnt_sel = 1;
    tick();
    chk("t3_adv_on_gnt", 64'(s_adv), 64'(1));

    // Flush in WAIT, data returns two cycles later and is dropped.
    flush = 1'b1; pc = 32'h40; tick(); flush = 1'b0;
    dec_ready = 1'b0; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 4 && outst; i++) tick();
    wait_req("t4_req", 12);
    flush = 1'b1; pc = 32'h80; tick(); flush = 1'b0;
    tick(); tick();
    chk("t4_valid_after_drop", 64'(instr_valid), 64'(0));
    wait_req("t4_new_req", 12);
    chk("t4_new_addr", 64'(s_addr), 64'(32'h80));

    // Flush with three entries and a same-cycle push/pop.
    lat_min = 1; lat_max = 1;
    flush = 1'b1; pc = 32'h100; tick(); flush = 1'b0;
    for (int i = 0; i < 30 && !(fq.size() == 3 && outst && mem_wait == 0); i++) tick();
    chk("t5_setup", 64'(fq.size() == 3 && outst && mem_wait == 0), 64'(1));
    dec_ready = 1'b1; flush = 1'b1; pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("t5_valid_cleared", 64'(instr_valid), 64'(0));

`ifdef FETCH_ALIGN_CHECK_EN
    flush = 1'b1; pc = 32'h6; tick(); flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_req", 64'(s_req), 64'(0));
      chk("t6_no_adv", 64'(s_adv), 64'(0));
    end
    chk("t6_fault_set", 64'(fetch_fault), 64'(1));
    flush = 1'b1; pc = 32'h8; tick(); flush = 1'b0;
    chk("t6_fault_clear", 64'(fetch_fault), 64'(0));
    wait_req("t6_req", 12);
    chk("t6_addr", 64'(s_addr), 64'(32'h8));
`else
    flush = 1'b1; pc = 32'h102; tick(); flush = 1'b0;
    wait_req("t6_unaligned_req", 12);
    chk("t6_unaligned_addr", 64'(s_addr), 64'(32'h102));
`endif

    // Randomized traffic: grant, latency, decode backpressure, flushes.
    gnt_sel = 2; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      dec_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(24, 0) == 0) begin
        flush = 1'b1;
        pc = $urandom & 32'h0000_fffc;
      end
      tick();
      flush = 1'b0;
    end

    // Asynchronous reset in the middle of traffic.
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(imem_bus.req), 64'(0));
    chk("arst_addr", 64'(imem_bus.addr), 64'(0));
    chk("arst_adv", 64'(pc_advance), 64'(0));
    chk("arst_valid", 64'(instr_valid), 64'(0));
    chk("arst_instr", 64'(instr), 64'(0));
    chk("arst_instr_pc", 64'(instr_pc), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
